// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and constants for the multi-port register file
package regfile_pkg;

    // Default geometry of the register file
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_MAX = 4;

    // Architectural zero register index
    localparam int REG_ZERO = 0;

    // Returns 1 when an address names a real (writable) register
    function automatic logic is_real_reg(input logic [31:0] addr);
        return (addr != 32'(REG_ZERO));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write busy vector and pending counter
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_wa,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic             wr_hit;
    logic             iss_hit;
    logic             inc_en;
    logic             dec_en;
    logic [DEPTH-1:0] busy_nxt;

    // Writes and issues to the zero register never touch the scoreboard
    assign wr_hit  = we && is_real_reg(32'(wa));
    assign iss_hit = iss_v && is_real_reg(32'(iss_wa));

    // A fresh producer on an idle register adds one pending entry
    assign inc_en  = iss_hit && !busy[iss_wa];
    // A retire drops one entry unless a new producer re-claims the same register
    assign dec_en  = wr_hit && busy[wa] && !(iss_hit && (iss_wa == wa));

    // Next busy vector: retire clears first, issue sets last so the new producer wins
    always_comb begin
        busy_nxt = busy;
        if (wr_hit) begin
            busy_nxt[wa] = 1'b0;
        end
        if (iss_hit) begin
            busy_nxt[iss_wa] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy bits and the running population count advance together
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= pend_cnt + {{ADDR_W{1'b0}}, inc_en} - {{ADDR_W{1'b0}}, dec_en};
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with scoreboard; REGFILE_BYPASS_EN enables write-first forwarding
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_wa,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .we       (we),
        .wa       (wa),
        .iss_v    (iss_v),
        .iss_wa   (iss_wa),
        .busy     (busy),
        .pend_cnt (pend_cnt)
    );

    // Storage array: cleared on reset, the zero register is never written
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != ZERO_A)) begin
            mem[wa] <= wd;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d_st;
        logic              b_st;

        assign a    = ra[i*ADDR_W +: ADDR_W];
        assign d_st = (a == ZERO_A) ? '0 : mem[a];
        assign b_st = (a == ZERO_A) ? 1'b0 : busy[a];

`ifdef REGFILE_BYPASS_EN
        // Write-first: a same-cycle retire to this port's register is seen immediately
        logic fwd;
        assign fwd                     = we && (wa != ZERO_A) && (wa == a);
        assign rd[i*DATA_W +: DATA_W]  = fwd ? wd : d_st;
        assign rd_busy[i]              = fwd ? 1'b0 : b_st;
`else
        assign rd[i*DATA_W +: DATA_W]  = d_st;
        assign rd_busy[i]              = b_st;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard-checked directed bench for regfile_mp
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     rstn;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     iss_v;
    logic [ADDR_W-1:0]        iss_wa;
    logic [ADDR_W:0]          pend_cnt;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_v    (iss_v),
        .iss_wa   (iss_wa),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_pend;
        logic [1:0]  port;
        logic [31:0] d;
        logic        b;
        logic [5:0]  pend;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passes = 0;

    exp_t        m_e;
    string       m_nm;
    logic [31:0] m_d;
    logic        m_b;

    // Monitor: drains expectations at the falling edge, away from state updates
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_e  = exp_q.pop_front();
            m_nm = name_q.pop_front();
            checks++;
            if (m_e.is_pend) begin
                if (pend_cnt === m_e.pend) passes++;
                else $display("FAIL %s: pend_cnt=%0d required %0d", m_nm, pend_cnt, m_e.pend);
            end else begin
                m_d = rd[m_e.port*DATA_W +: DATA_W];
                m_b = rd_busy[m_e.port];
                if (m_d === m_e.d && m_b === m_e.b) passes++;
                else $display("FAIL %s: rd=%h busy=%b required rd=%h busy=%b",
                              m_nm, m_d, m_b, m_e.d, m_e.b);
            end
        end
    end

    task automatic exp_rd(input string nm, input int p, input logic [31:0] d, input logic b);
        exp_t e;
        e.is_pend = 1'b0;
        e.port    = 2'(p);
        e.d       = d;
        e.b       = b;
        e.pend    = '0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp_pend(input string nm, input int cnt);
        exp_t e;
        e.is_pend = 1'b1;
        e.port    = '0;
        e.d       = '0;
        e.b       = 1'b0;
        e.pend    = 6'(cnt);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_ra(input logic [4:0] a1, input logic [4:0] a0);
        ra = {a1, a0};
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] a);
        iss_v = 1'b1; iss_wa = a;
        tick();
        iss_v = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ra = '0; we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_wa = '0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        set_ra(5'd7, 5'd1);
        exp_rd("rst_p0", 0, 32'h0, 1'b0);
        exp_rd("rst_p1", 1, 32'h0, 1'b0);
        exp_pend("rst_pend", 0);
        settle();

        // Basic write/read
        do_write(5'd1, 32'h1145);
        do_write(5'd2, 32'h1919);
        set_ra(5'd2, 5'd1);
        exp_rd("wr_r1", 0, 32'h1145, 1'b0);
        exp_rd("wr_r2", 1, 32'h1919, 1'b0);
        settle();

        // Zero register ignores write and issue
        we = 1'b1; wa = 5'd0; wd = 32'h114514; iss_v = 1'b1; iss_wa = 5'd0;
        tick();
        we = 1'b0; iss_v = 1'b0;
        set_ra(5'd0, 5'd0);
        exp_rd("r0_p0", 0, 32'h0, 1'b0);
        exp_rd("r0_p1", 1, 32'h0, 1'b0);
        exp_pend("r0_pend", 0);
        settle();

        // Scoreboard issue, including a repeat issue
        do_issue(5'd3);
        do_issue(5'd5);
        do_issue(5'd3);
        set_ra(5'd5, 5'd3);
        exp_pend("iss_pend", 2);
        exp_rd("iss_r3", 0, 32'h0, 1'b1);
        exp_rd("iss_r5", 1, 32'h0, 1'b1);
        settle();

        // Retire r3
        do_write(5'd3, 32'h33);
        exp_pend("ret_pend", 1);
        exp_rd("ret_r3", 0, 32'h33, 1'b0);
        exp_rd("ret_r5", 1, 32'h0, 1'b1);
        settle();

        // Simultaneous write and issue on r4
        we = 1'b1; wa = 5'd4; wd = 32'h44; iss_v = 1'b1; iss_wa = 5'd4;
        tick();
        we = 1'b0; iss_v = 1'b0;
        set_ra(5'd4, 5'd4);
        exp_rd("sim_r4", 0, 32'h44, 1'b1);
        exp_pend("sim_pend", 2);
        settle();

        // Write to an idle register leaves it idle
        do_write(5'd6, 32'h66);
        set_ra(5'd1, 5'd6);
        exp_rd("idle_r6", 0, 32'h66, 1'b0);
        exp_pend("idle_pend", 2);
        settle();

        // Forwarding window on busy r6
        do_issue(5'd6);
        exp_pend("r6_pend", 3);
        we = 1'b1; wa = 5'd6; wd = 32'hDEAD;
`ifdef REGFILE_BYPASS_EN
        exp_rd("fwd_r6", 0, 32'hDEAD, 1'b0);
`else
        exp_rd("fwd_r6", 0, 32'h66, 1'b1);
`endif
        exp_rd("fwd_r1", 1, 32'h1145, 1'b0);
        settle();
        tick();
        we = 1'b0;
        exp_rd("post_r6", 0, 32'hDEAD, 1'b0);
        exp_pend("post_pend", 2);
        settle();

        // Re-issue to an already busy register
        do_issue(5'd5);
        exp_pend("reiss_pend", 2);
        settle();

        // Reset mid-operation with concurrent write and issue
        do_issue(5'd7);
        do_issue(5'd8);
        exp_pend("pre_rst_pend", 4);
        settle();
        rstn = 1'b0; we = 1'b1; wa = 5'd9; wd = 32'h99; iss_v = 1'b1; iss_wa = 5'd10;
        tick();
        rstn = 1'b1; we = 1'b0; iss_v = 1'b0;
        exp_pend("mrst_pend", 0);
        set_ra(5'd10, 5'd9);
        exp_rd("mrst_r9", 0, 32'h0, 1'b0);
        exp_rd("mrst_r10", 1, 32'h0, 1'b0);
        settle();
        set_ra(5'd5, 5'd1);
        exp_rd("mrst_r1", 0, 32'h0, 1'b0);
        exp_rd("mrst_r5", 1, 32'h0, 1'b0);
        settle();
        tick();

        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: pending=%0d required 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
